lab71_soc_led_pulse_pio: RTL and testbench

LAB71_SOC_LED_PULSE_PIO -- requirements
Module: lab71_soc_led_pulse_pio

---
 rtl/lab71_soc_led_pulse_pio_if.sv | 25 ++
 rtl/lab71_soc_led_pulse_pio.sv | 108 ++++++++++
 tb/tb_lab71_soc_led_pulse_pio.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lab71_soc_led_pulse_pio_if.sv
// Avalon-MM slave bus bundle for the LED pulse PIO.
// master drives address/strobes/writedata; slave returns registered readdata.
interface lab71_soc_led_pulse_pio_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/lab71_soc_led_pulse_pio.sv
// LED PIO with a one-shot XOR pulse mask; STATUS holds busy and a sticky overrun flag.
// Define LED_PULSE_READBACK_EN to read back DATA/PULSE_LEN/MASK; otherwise only STATUS reads.
module lab71_soc_led_pulse_pio (
  input  logic                            clk,
  input  logic                            reset_n,
  lab71_soc_led_pulse_pio_if.slave        bus,
  output logic [7:0]                      out_port
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_PULSE = 1'b1;

  logic [7:0]  r_data, w_data_d;
  logic [15:0] r_len, w_len_d;
  logic [7:0]  r_mask, w_mask_d;
  logic [15:0] r_cnt, w_cnt_d;
  logic [0:0]  r_state, w_state_d;
  logic        r_ovr, w_ovr_d;
  logic [31:0] r_rdata, w_rdata_d;
  logic [7:0]  r_out, w_out_d;

  logic        w_wr, w_trig, w_set_ovr;
  logic [31:0] w_status;
  logic        w_unused_wd;

  assign w_unused_wd = ^bus.writedata[31:16];
  assign w_wr        = bus.chipselect & ~bus.write_n;
  assign w_trig      = w_wr && (bus.address == 2'd2);
  assign w_status    = {30'd0, r_ovr, r_state == ST_PULSE};

  always_comb begin
    w_data_d  = r_data;
    w_len_d   = r_len;
    w_mask_d  = r_mask;
    w_cnt_d   = r_cnt;
    w_state_d = r_state;
    w_set_ovr = 1'b0;

    if (w_wr && bus.address == 2'd0) w_data_d = bus.writedata[7:0];
    if (w_wr && bus.address == 2'd1) w_len_d  = bus.writedata[15:0];

    if (r_state == ST_IDLE) begin
      if (w_trig && bus.writedata[7:0] != 8'h00) begin
        w_mask_d  = bus.writedata[7:0];
        w_cnt_d   = (r_len == 16'd0) ? 16'd1 : r_len;
        w_state_d = ST_PULSE;
      end
    end else begin
      // A trigger on the final pulse edge still sees PULSE, so it is an overrun.
      w_cnt_d   = r_cnt - 16'd1;
      w_set_ovr = w_trig;
      if (r_cnt == 16'd1) w_state_d = ST_IDLE;
    end

    if (w_set_ovr) begin
      w_ovr_d = 1'b1;
    end else if (w_wr && bus.address == 2'd3 && bus.writedata[1]) begin
      w_ovr_d = 1'b0;
    end else begin
      w_ovr_d = r_ovr;
    end

    // Output computed from next-state values so out_port is a pure flop output.
    w_out_d = w_data_d ^ ((w_state_d == ST_PULSE) ? w_mask_d : 8'h00);
  end

  always_comb begin
    w_rdata_d = 32'd0;
    unique case (bus.address)
`ifdef LED_PULSE_READBACK_EN
      2'd0:    w_rdata_d = {24'd0, r_data};
      2'd1:    w_rdata_d = {16'd0, r_len};
      2'd2:    w_rdata_d = {24'd0, r_mask};
`else
      2'd0:    w_rdata_d = 32'd0;
      2'd1:    w_rdata_d = 32'd0;
      2'd2:    w_rdata_d = 32'd0;
`endif
      default: w_rdata_d = w_status;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data  <= 8'h00;
      r_len   <= 16'd0;
      r_mask  <= 8'h00;
      r_cnt   <= 16'd0;
      r_state <= ST_IDLE;
      r_ovr   <= 1'b0;
      r_rdata <= 32'd0;
      r_out   <= 8'h00;
    end else begin
      r_data  <= w_data_d;
      r_len   <= w_len_d;
      r_mask  <= w_mask_d;
      r_cnt   <= w_cnt_d;
      r_state <= w_state_d;
      r_ovr   <= w_ovr_d;
      r_rdata <= w_rdata_d;
      r_out   <= w_out_d;
    end
  end

  assign bus.readdata = r_rdata;
  assign out_port     = r_out;

endmodule

// File: tb/tb_lab71_soc_led_pulse_pio.sv
// Directed bench for lab71_soc_led_pulse_pio with a queue of expected out_port/readdata values.
// Readback expectations follow LED_PULSE_READBACK_EN.
module tb_lab71_soc_led_pulse_pio;

`ifdef LED_PULSE_READBACK_EN
  localparam logic [31:0] RbMask = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] RbMask = 32'h0000_0000;
`endif

  logic       clk;
  logic       reset_n;
  logic [7:0] out_port;
  lab71_soc_led_pulse_pio_if bus_if ();

  lab71_soc_led_pulse_pio dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus_if),
    .out_port (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;   // 0 out_port, 1 readdata, 2 aux
    logic [31:0] exp;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] aux;

  task automatic push(input string tag, input int sel, input logic [31:0] e);
    exp_t x;
    x.tag = tag;
    x.sel = sel;
    x.exp = e;
    q.push_back(x);
  endtask

  task automatic drain();
    exp_t        x;
    logic [31:0] obs;
    while (q.size() > 0) begin
      x   = q.pop_front();
      obs = (x.sel == 0) ? {24'd0, out_port} : (x.sel == 1) ? bus_if.readdata : aux;
      checks++;
      assert (obs === x.exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", x.tag, obs, x.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic idle(input logic [1:0] a);
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.address    = a;
    bus_if.writedata  = 32'd0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    bus_if.address    = a;
    bus_if.writedata  = d;
  endtask

  task automatic wr_tick(input logic [1:0] a, input logic [31:0] d, input logic [7:0] eo);
    wr(a, d);
    push("wr_out", 0, {24'd0, eo});
    tick();
    idle(2'd3);
  endtask

  initial begin
    int n;
    idle(2'd3);
    reset_n = 1'b0;
    aux     = 32'd0;

    // Reset state
    push("rst_out", 0, 32'd0);
    push("rst_rd", 1, 32'd0);
    tick();
    reset_n = 1'b1;

    // DATA write and readback
    wr_tick(2'd0, 32'h0000_00A5, 8'hA5);
    idle(2'd0);
    push("data_rd", 1, 32'h0000_00A5 & RbMask);
    push("data_out", 0, 32'h0000_00A5);
    tick();
    idle(2'd3);
    push("status_idle", 1, 32'd0);
    tick();

    // 3-cycle pulse on all bits
    wr_tick(2'd0, 32'h0F, 8'h0F);
    wr_tick(2'd1, 32'd3, 8'h0F);
    wr(2'd2, 32'hFF);
    push("p3_start", 0, 32'hF0);
    tick();
    idle(2'd3);
    for (int i = 1; i <= 4; i++) begin
      push("p3_out", 0, (i < 3) ? 32'hF0 : 32'h0F);
      push("p3_busy", 1, (i <= 3) ? 32'd1 : 32'd0);
      tick();
    end
    idle(2'd2);
    push("mask_rd", 1, 32'hFF & RbMask);
    tick();
    idle(2'd3);

    // PULSE_LEN=0 gives one cycle
    wr_tick(2'd0, 32'h00, 8'h00);
    wr_tick(2'd1, 32'd0, 8'h00);
    wr(2'd2, 32'h01);
    push("p0_start", 0, 32'h01);
    tick();
    idle(2'd3);
    push("p0_end", 0, 32'h00);
    tick();

    // Overrun during a 10-cycle pulse
    wr_tick(2'd1, 32'd10, 8'h00);
    wr(2'd2, 32'h01);
    push("p10_start", 0, 32'h01);
    tick();
    idle(2'd3);
    for (int i = 1; i <= 3; i++) begin
      push("p10_out", 0, 32'h01);
      push("p10_st1", 1, 32'd1);
      tick();
    end
    wr(2'd2, 32'h02);
    push("p10_ovr_out", 0, 32'h01);
    tick();
    idle(2'd3);
    for (int i = 5; i <= 9; i++) begin
      push("p10_out", 0, 32'h01);
      push("p10_st3", 1, 32'd3);
      tick();
    end
    push("p10_end", 0, 32'h00);
    push("p10_st3", 1, 32'd3);
    tick();
    push("p10_after", 0, 32'h00);
    push("p10_st2", 1, 32'd2);
    tick();
    wr(2'd3, 32'd2);
    push("clr_rd", 1, 32'd2);
    tick();
    idle(2'd3);
    push("clr_st0", 1, 32'd0);
    tick();

    // Trigger on the final pulse edge counts as overrun
    wr_tick(2'd1, 32'd2, 8'h00);
    wr(2'd2, 32'h01);
    push("p2_start", 0, 32'h01);
    tick();
    idle(2'd3);
    push("p2_out", 0, 32'h01);
    tick();
    wr(2'd2, 32'h04);
    push("p2_edge_out", 0, 32'h00);
    tick();
    idle(2'd3);
    push("p2_ovr", 1, 32'd2);
    push("p2_idle_out", 0, 32'h00);
    tick();
    idle(2'd2);
    push("p2_mask_kept", 1, 32'h01 & RbMask);
    tick();
    wr_tick(2'd3, 32'd2, 8'h00);
    push("p2_clr", 1, 32'd0);
    tick();

    // Zero-mask trigger is a no-op
    wr_tick(2'd2, 32'h00, 8'h00);
    push("z_st", 1, 32'd0);
    tick();
    idle(2'd2);
    push("z_mask", 1, 32'h01 & RbMask);
    tick();
    idle(2'd3);

    // Asynchronous reset mid-pulse
    wr_tick(2'd1, 32'd100, 8'h00);
    wr(2'd2, 32'h80);
    push("r_start", 0, 32'h80);
    tick();
    idle(2'd3);
    for (int i = 1; i < 20; i++) tick();
    push("r_mid", 0, 32'h80);
    drain();
    reset_n = 1'b0;
    #1;
    push("r_async_out", 0, 32'd0);
    push("r_async_rd", 1, 32'd0);
    drain();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push("r_after_out", 0, 32'd0);
      push("r_after_st", 1, 32'd0);
      tick();
    end

    // Max length pulse without wrap
    wr_tick(2'd1, 32'h0000_FFFF, 8'h00);
    wr(2'd2, 32'h01);
    tick();
    idle(2'd3);
    n = 0;
    while (out_port[0] && n < 70000) begin
      n++;
      @(posedge clk);
      #1;
    end
    aux = n;
    push("max_len", 2, 32'd65535);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
